// File: rtl/dmem_line_responder_pkg.sv
// Shared types and helpers for the data-side line responder: line geometry,
// FSM state encoding and the byte-masked line merge.
package dmem_pkg;

    localparam int LINE_BITS = 128;
    localparam int MASK_BITS = LINE_BITS / 8;
    localparam int CNT_BITS  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bytes with their enable set come from wdata, the rest keep the old line.
    function automatic logic [LINE_BITS-1:0] merge_line(
        input logic [LINE_BITS-1:0] line,
        input logic [LINE_BITS-1:0] wdata,
        input logic [MASK_BITS-1:0] wmask
    );
        logic [LINE_BITS-1:0] merged;
        merged = line;
        for (int i = 0; i < MASK_BITS; i++) begin
            if (wmask[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_line_responder_if.sv
// Line-granular request/valid handshake between the MEM-stage data cache
// (master) and its backing store (slave).
interface dmem_line_responder_if #(
    parameter int LINE_BITS = dmem_pkg::LINE_BITS,
    parameter int ADDR_BITS = 6
);
    logic                   MEM_mem_req;
    logic                   MEM_mem_we;
    logic [ADDR_BITS-1:0]   MEM_mem_addr;
    logic [LINE_BITS-1:0]   MEM_mem_wdata;
    logic [LINE_BITS/8-1:0] MEM_mem_wmask;
    logic [LINE_BITS-1:0]   MEM_mem_rdata;
    logic                   MEM_mem_valid;
    logic                   MEM_mem_busy;

    modport master (
        output MEM_mem_req, MEM_mem_we, MEM_mem_addr, MEM_mem_wdata, MEM_mem_wmask,
        input  MEM_mem_rdata, MEM_mem_valid, MEM_mem_busy
    );

    modport slave (
        input  MEM_mem_req, MEM_mem_we, MEM_mem_addr, MEM_mem_wdata, MEM_mem_wmask,
        output MEM_mem_rdata, MEM_mem_valid, MEM_mem_busy
    );
endinterface

// File: rtl/dmem_line_responder_array.sv
// Line storage: one shared address, combinational read, byte-masked
// synchronous write. Contents survive reset.
module dmem_line_array #(
    parameter int LINE_BITS = dmem_pkg::LINE_BITS,
    parameter int ADDR_BITS = 6
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic [LINE_BITS-1:0]   wdata,
    input  logic [LINE_BITS/8-1:0] wmask,
    output logic [LINE_BITS-1:0]   rdata
);
    import dmem_pkg::*;

    logic [LINE_BITS-1:0] mem_reg [2**ADDR_BITS];

    assign rdata = mem_reg[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= merge_line(rdata, wdata, wmask);
        end
    end

endmodule

// File: rtl/dmem_line_responder.sv
// Fixed-latency backing store for the data cache: accepts one line request
// when idle, answers LATENCY cycles later with a single valid pulse.
module dmem_line_responder #(
    parameter int LINE_BITS = dmem_pkg::LINE_BITS,
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_line_responder_if.slave  bus
);
    import dmem_pkg::*;

    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

    state_t                 state_reg, state_next;
    logic [CNT_BITS-1:0]    cnt_reg, cnt_next;
    logic                   we_reg, we_next;
    logic [ADDR_BITS-1:0]   addr_reg, addr_next;
    logic [LINE_BITS-1:0]   wdata_reg, wdata_next;
    logic [LINE_BITS/8-1:0] wmask_reg, wmask_next;
    logic [LINE_BITS-1:0]   rdata_hold_reg, rdata_hold_next;

    logic                   in_resp;
    logic [LINE_BITS-1:0]   line_rd;
    logic [LINE_BITS-1:0]   line_out;

    assign in_resp = (state_reg == RESP);

    dmem_line_array #(
        .LINE_BITS (LINE_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (in_resp && we_reg),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .wmask (wmask_reg),
        .rdata (line_rd)
    );

    // A write responds with the line as it will look once the RESP edge commits it.
    assign line_out = we_reg ? merge_line(line_rd, wdata_reg, wmask_reg) : line_rd;

    assign bus.MEM_mem_busy  = (state_reg != IDLE);
    assign bus.MEM_mem_valid = in_resp;
    assign bus.MEM_mem_rdata = in_resp ? line_out : rdata_hold_reg;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wmask_next      = wmask_reg;
        rdata_hold_next = rdata_hold_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.MEM_mem_req) begin
                    we_next    = bus.MEM_mem_we;
                    addr_next  = bus.MEM_mem_addr;
                    wdata_next = bus.MEM_mem_wdata;
                    wmask_next = bus.MEM_mem_wmask;
                    cnt_next   = CNT_LOAD;
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_BITS'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rdata_hold_next = line_out;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
            rdata_hold_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            wmask_reg      <= wmask_next;
            rdata_hold_reg <= rdata_hold_next;
        end
    end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Bench for dmem_line_responder: three instances (LATENCY 2, 1, 15) share one
// stimulus stream; a timestamp-based model is compared every cycle.
module tb_dmem_line_responder;

    localparam int NI = 3;
    localparam logic [127:0] P5 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] P7 = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req, we;
    logic [5:0]   addr;
    logic [127:0] wdata;
    logic [15:0]  wmask;

    logic         valid_w [NI];
    logic         busy_w  [NI];
    logic [127:0] rdata_w [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        dmem_line_responder_if #(.LINE_BITS(128), .ADDR_BITS(6)) bus ();
        assign bus.MEM_mem_req   = req;
        assign bus.MEM_mem_we    = we;
        assign bus.MEM_mem_addr  = addr;
        assign bus.MEM_mem_wdata = wdata;
        assign bus.MEM_mem_wmask = wmask;
        assign valid_w[gi] = bus.MEM_mem_valid;
        assign busy_w[gi]  = bus.MEM_mem_busy;
        assign rdata_w[gi] = bus.MEM_mem_rdata;

        dmem_line_responder #(
            .LINE_BITS (128),
            .ADDR_BITS (6),
            .LATENCY   (gi == 0 ? 2 : (gi == 1 ? 1 : 15))
        ) u_dut (
            .clk (clk),
            .rst (rst_n),
            .bus (bus.slave)
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model: each accepted request is a (start, done) window
    int           lat [NI] = '{2, 1, 15};
    logic [127:0] mmem [NI][64];
    bit           pend [NI];
    int           done_at [NI];
    logic         m_we [NI];
    logic [5:0]   m_addr [NI];
    logic [127:0] m_wd [NI];
    logic [15:0]  m_wm [NI];
    logic         exp_valid [NI];
    logic         exp_busy [NI];
    logic [127:0] exp_rdata [NI];
    int           cyc = 0;
    bit           live = 0;

    function automatic logic [127:0] apply_bytes(input logic [127:0] base,
                                                 input logic [127:0] d,
                                                 input logic [15:0] m);
        logic [127:0] r;
        r = base;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    initial begin
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 64; a++) mmem[k][a] = '0;
            pend[k] = 0; done_at[k] = 0;
            exp_valid[k] = 0; exp_busy[k] = 0; exp_rdata[k] = '0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        live = 1;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                pend[k] = 0;
                exp_valid[k] = 0;
                exp_busy[k] = 0;
                exp_rdata[k] = '0;
            end else begin
                if (pend[k] && (cyc - 1 == done_at[k])) begin
                    // the edge that closes the response cycle commits a write
                    if (m_we[k]) mmem[k][m_addr[k]] = apply_bytes(mmem[k][m_addr[k]], m_wd[k], m_wm[k]);
                    pend[k] = 0;
                end else if (!pend[k] && req) begin
                    pend[k] = 1;
                    done_at[k] = cyc - 1 + lat[k];
                    m_we[k] = we; m_addr[k] = addr; m_wd[k] = wdata; m_wm[k] = wmask;
                end
                exp_busy[k]  = pend[k];
                exp_valid[k] = pend[k] && (cyc == done_at[k]);
                if (exp_valid[k]) begin
                    exp_rdata[k] = m_we[k] ? apply_bytes(mmem[k][m_addr[k]], m_wd[k], m_wm[k])
                                           : mmem[k][m_addr[k]];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("cyc%0d inst%0d busy", cyc, k), 128'(busy_w[k]), 128'(exp_busy[k]));
                check($sformatf("cyc%0d inst%0d valid", cyc, k), 128'(valid_w[k]), 128'(exp_valid[k]));
                check($sformatf("cyc%0d inst%0d rdata", cyc, k), rdata_w[k], exp_rdata[k]);
            end
        end
    end

    // ---------------- directed stimulus
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input logic w, input logic [5:0] a, input logic [127:0] d, input logic [15:0] m);
        req = 1'b1; we = w; addr = a; wdata = d; wmask = m;
        step();
        req = 1'b0;
    endtask

    int cnt [NI];
    int first [NI];

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wmask = '0;
        idle(3);
        check("reset valid", 128'(valid_w[0]), 128'd0);
        check("reset busy", 128'(busy_w[0]), 128'd0);
        check("reset rdata", rdata_w[0], 128'd0);
        rst_n = 1'b1;
        idle(10);
        check("idle busy", 128'(busy_w[0]), 128'd0);
        $display("txn: reset and 10 idle cycles");

        issue(1'b1, 6'd5, P5, 16'hFFFF); idle(20);
        issue(1'b1, 6'd3, '0, 16'hFFFF); idle(20);
        issue(1'b1, 6'd7, P7, 16'hFFFF); idle(20);
        $display("txn: preload lines 5, 3, 7");

        issue(1'b0, 6'd5, '0, '0);
        check("read c1 busy", 128'(busy_w[0]), 128'd1);
        check("read c1 valid", 128'(valid_w[0]), 128'd0);
        step();
        check("read c2 valid", 128'(valid_w[0]), 128'd1);
        check("read c2 rdata", rdata_w[0], P5);
        step();
        check("read c3 busy", 128'(busy_w[0]), 128'd0);
        check("read c3 valid", 128'(valid_w[0]), 128'd0);
        $display("txn: read line 5 latency check");
        idle(20);

        issue(1'b1, 6'd3, {16{8'hAA}}, 16'h000F);
        step();
        check("mwrite c2 valid", 128'(valid_w[0]), 128'd1);
        idle(20);
        issue(1'b0, 6'd3, '0, '0);
        step();
        check("mwrite readback", rdata_w[0], 128'h000000000000000000000000AAAAAAAA);
        $display("txn: masked write line 3 then read");
        idle(20);

        issue(1'b1, 6'd5, '1, 16'h0000); idle(20);
        issue(1'b0, 6'd5, '0, '0);
        step();
        check("mask0 readback", rdata_w[0], P5);
        $display("txn: zero-mask write line 5 then read");
        idle(20);

        cnt[0] = 0;
        req = 1'b1; we = 1'b0; addr = 6'd5; wdata = '0; wmask = '0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (valid_w[0]) cnt[0]++;
            if (i == 1) begin we = 1'b1; wdata = '1; wmask = 16'hFFFF; end
            if (i == 3) req = 1'b0;
        end
        check("busy-drop pulses", 128'(cnt[0]), 128'd1);
        idle(20);
        issue(1'b0, 6'd5, '0, '0);
        step();
        check("busy-drop readback", rdata_w[0], P5);
        $display("txn: requests while busy dropped");
        idle(20);

        issue(1'b1, 6'd7, '1, 16'hFFFF);
        rst_n = 1'b0;
        step();
        check("midrst busy", 128'(busy_w[0]), 128'd0);
        rst_n = 1'b1;
        idle(20);
        issue(1'b0, 6'd7, '0, '0);
        step();
        check("midrst readback", rdata_w[0], P7);
        $display("txn: reset during write to line 7");
        idle(20);

        for (int k = 0; k < NI; k++) first[k] = -1;
        req = 1'b1; we = 1'b0; addr = 6'd3;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) req = 1'b0;
            for (int k = 0; k < NI; k++) if (valid_w[k] && first[k] < 0) first[k] = i;
        end
        check("sweep lat2", 128'(first[0]), 128'd2);
        check("sweep lat1", 128'(first[1]), 128'd1);
        check("sweep lat15", 128'(first[2]), 128'd15);
        $display("txn: latency sweep single read");
        idle(5);

        for (int k = 0; k < NI; k++) cnt[k] = 0;
        req = 1'b1; we = 1'b0; addr = 6'd5;
        for (int i = 1; i <= 25; i++) begin
            step();
            for (int k = 0; k < NI; k++) if (valid_w[k]) cnt[k]++;
            if (i == 9) req = 1'b0;
        end
        check("b2b lat2 pulses", 128'(cnt[0]), 128'd3);
        check("b2b lat1 pulses", 128'(cnt[1]), 128'd5);
        check("b2b lat15 pulses", 128'(cnt[2]), 128'd1);
        $display("txn: back-to-back requests held 9 cycles");
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
